n_bit_4_to_1_rr_collector_with_enable: RTL and testbench
========================================================

Name: n_bit_4_to_1_rr_collector_with_enable

Overview:
Merges four N-bit source lanes into one N-bit output stream. It is the collecting end opposite the 1-to-4 demux with enable. Each lane uses a valid/ready handshake. A round-robin arbiter picks one requesting lane per cycle and captures it into a registered output stage that carries a 2-bit lane tag, so a downstream 1-to-4 demux can route the word back by tag.

Parameters:
N, 4, data width of every lane and of the output.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk.
enable  input  1  high permits new grants; low blocks new grants only.
in0  input  N  lane 0 data.
in1  input  N  lane 1 data.
in2  input  N  lane 2 data.
in3  input  N  lane 3 data.
valid  input  4  valid[k] high means lane k presents a word.
ready  output  4  ready[k] high means lane k's word is accepted this cycle; at most one bit is high.
y  output  N  registered output data.
y_select  output  2  registered lane index of the word on y.
y_valid  output  1  y/y_select hold a word.
y_ready  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): y=0, y_select=0, y_valid=0, round-robin pointer ptr=0. ready=0 is combinational while reset is asserted.
- A slot is free when y_valid==0 OR y_ready==1. Same-cycle drain-and-refill is allowed, giving one word per cycle throughput.
- Grant is combinational:
  - When enable is high and the slot is free, grant the first k with valid[k]==1, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
  - ready = one-hot of the grant; otherwise ready=0.
  - ready may depend combinationally on y_ready, valid and enable.
- Transfer on lane k happens when valid[k] & ready[k]. At the next edge:
  - y <= in_k, y_select <= k, y_valid <= 1.
  - ptr <= (k+1) mod 4, with 2-bit wrap so that after lane 3, ptr=0.
- Downstream pop: when y_valid & y_ready with no new transfer, y_valid <= 0 at the next edge. y and y_select hold their last values.
- Simultaneous pop and transfer: the new word replaces the old one and y_valid stays 1.
- Stall: when y_valid==1 and y_ready==0, ready=0, and y, y_select and y_valid are held stable.
- Latency: a lane word appears on y exactly 1 cycle after its transfer cycle.
- No requests: ptr does not change and y_valid follows the pop rule.
- enable low:
  - ready=0 and ptr is frozen.
  - A word already in the output stage still drains normally via y_ready.
  - enable rising resumes arbitration from the frozen ptr.
- Source rule (checked by the bench, not enforced by this block): a lane holds valid and its data stable until accepted. The block never drops or duplicates a word.
- Fairness: a lane with valid held high is granted within 4 free-slot cycles.
- Reset mid-operation:
  - A held output word is discarded, y_valid=0 and ptr=0 immediately.
  - No ready is asserted during reset.
  - The first cycle after deassertion arbitrates from lane 0.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with valid=4'b1111 -> ready=0, y_valid=0, y=0; first cycle after release with y_ready=1 -> ready=4'b0001, and next cycle y=in0, y_select=0.
- Round-robin, N=4: in0..in3 = 4'hA, 4'hB, 4'hC, 4'hD, valid=4'b1111, y_ready=1, enable=1 -> y sequence A, B, C, D, A over consecutive cycles, y_select 0,1,2,3,0, y_valid high every cycle, ptr wraps 3->0.
- Skip and wrap: ptr=2 after a lane-1 grant, valid=4'b0011 -> lane 0 granted next, then lane 1; lanes 2 and 3 get no ready.
- Backpressure: y holds 4'h5 with y_valid=1 and y_ready=0 for 4 cycles while valid=4'b0100 -> ready=0, y=5 held; y_ready=1 -> same cycle ready=4'b0100, next cycle y=in2, y_select=2.
- Enable gating: enable=0 with a word in y and y_ready=1 -> word drains, y_valid=0, ready stays 0, ptr unchanged; enable=1 -> grant resumes at the frozen ptr.
- Reset mid-stall: y_valid=1, y=4'h9, y_ready=0, then rst_n pulsed low -> y_valid=0, y=0 immediately, and after release arbitration starts at lane 0.

Source files
------------

// File: rtl/n_bit_4_to_1_rr_collector_with_enable.sv
// Four-lane round-robin collector: arbitrates valid/ready source lanes into a
// single registered output stage tagged with the winning lane index.

// Per-lane grant cell: a lane wins when it requests, arbitration is open,
// and no other requesting lane sits closer to the round-robin pointer.
module n_bit_4_to_1_rr_collector_with_enable_lane #(
    parameter int NUM_LANES = 4,
    parameter int PW        = 2,
    parameter int LANE      = 0
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PW-1:0]        ptr,
    input  logic                 arb_en,
    output logic                 grant
);
    logic [PW-1:0] my_dist;
    logic [PW-1:0] other_dist;
    logic          blocked;

    // Priority distance wraps naturally in PW bits (modulo NUM_LANES).
    always_comb begin
        my_dist    = PW'(LANE) - ptr;
        other_dist = '0;
        blocked    = 1'b0;
        for (int j = 0; j < NUM_LANES; j++) begin
            other_dist = PW'(j) - ptr;
            if ((j != LANE) && req[j] && (other_dist < my_dist))
                blocked = 1'b1;
        end
        grant = arb_en & req[LANE] & ~blocked;
    end
endmodule

module n_bit_4_to_1_rr_collector_with_enable #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [3:0]   valid,
    output logic [3:0]   ready,
    output logic [N-1:0] y,
    output logic [1:0]   y_select,
    output logic         y_valid,
    input  logic         y_ready
);
    localparam int NUM_LANES = 4;
    localparam int PW        = 2;

    logic [NUM_LANES-1:0][N-1:0] lane_data;
    logic [NUM_LANES-1:0]        grant;
    logic [PW-1:0]               ptr;
    logic [PW-1:0]               gnt_idx;
    logic [N-1:0]                gnt_data;
    logic                        slot_free;
    logic                        arb_en;
    logic                        take;

    assign lane_data = {in3, in2, in1, in0};

    // The slot can take a word when empty or being drained this same cycle.
    // Reset is folded in so no ready escapes while rst_n is low.
    assign slot_free = ~y_valid | y_ready;
    assign arb_en    = rst_n & enable & slot_free;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            n_bit_4_to_1_rr_collector_with_enable_lane #(
                .NUM_LANES(NUM_LANES),
                .PW       (PW),
                .LANE     (g)
            ) u_lane (
                .req   (valid),
                .ptr   (ptr),
                .arb_en(arb_en),
                .grant (grant[g])
            );
        end
    endgenerate

    assign ready = grant;
    assign take  = |grant;

    // Encode the one-hot grant and select the winning lane's word.
    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (grant[k])
                gnt_idx = PW'(k);
        end
        gnt_data = lane_data[gnt_idx];
    end

    // Output stage and pointer: capture on transfer, clear valid on a bare pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= '0;
            y_select <= '0;
            y_valid  <= 1'b0;
            ptr      <= '0;
        end else if (take) begin
            y        <= gnt_data;
            y_select <= gnt_idx;
            y_valid  <= 1'b1;
            ptr      <= gnt_idx + PW'(1);
        end else if (y_valid && y_ready) begin
            y_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_n_bit_4_to_1_rr_collector_with_enable.sv
// Randomized and directed bench for the 4-to-1 round-robin collector, checked
// against a transaction-level model of the arbitration rules.
module tb_n_bit_4_to_1_rr_collector_with_enable;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] in0, in1, in2, in3;
    logic [3:0]   valid;
    logic [3:0]   ready;
    logic [N-1:0] y;
    logic [1:0]   y_select;
    logic         y_valid;
    logic         y_ready;

    int tests = 0;
    int fails = 0;

    // model state
    int           m_ptr;
    bit           m_yv;
    logic [N-1:0] m_y;
    int           m_sel;

    n_bit_4_to_1_rr_collector_with_enable #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .valid(valid), .ready(ready),
        .y(y), .y_select(y_select), .y_valid(y_valid), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] lane_word(input int k);
        case (k)
            0: return in0;
            1: return in1;
            2: return in2;
            default: return in3;
        endcase
    endfunction

    // Expected ready: first valid lane scanning from ptr, if allowed at all.
    function automatic logic [3:0] model_ready();
        if (!rst_n || !enable || (m_yv && !y_ready)) return 4'b0000;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (m_ptr + i) % 4;
            if (valid[k]) return 4'(1 << k);
        end
        return 4'b0000;
    endfunction

    // Advance one clock and update the model from the pre-edge inputs.
    task automatic tick();
        logic [3:0] g;
        logic [N-1:0] w;
        int k;
        bit pop;
        g = model_ready();
        k = -1;
        for (int i = 0; i < 4; i++) if (g[i]) k = i;
        w = (k >= 0) ? lane_word(k) : '0;
        pop = m_yv && y_ready;
        @(posedge clk);
        if (rst_n) begin
            if (k >= 0) begin
                m_y = w; m_sel = k; m_yv = 1; m_ptr = (k + 1) % 4;
            end else if (pop) begin
                m_yv = 0;
            end
        end
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        m_ptr = 0; m_yv = 0; m_y = '0; m_sel = 0;
        #1;
    endtask

    task automatic pulse_reset();
        assert_reset();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        enable = 1; valid = 4'b1111; y_ready = 1;
        in0 = 4'h3; in1 = 4'h4; in2 = 4'h6; in3 = 4'h8;
        assert_reset();
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (ready !== 4'b0000 || y_valid !== 1'b0 || y !== 4'h0) begin
                fails++;
                $display("FAIL reset_hold c=%0d: ready=%b y_valid=%b y=%h, want 0000/0/0", c, ready, y_valid, y);
            end
            tick();
        end
        rst_n = 1'b1; #1;
        tests++;
        if (ready !== 4'b0001) begin
            fails++;
            $display("FAIL reset_first_grant: ready=%b want 0001", ready);
        end
        tick();
        tests++;
        if (y !== 4'h3 || y_select !== 2'd0 || y_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_word: y=%h sel=%0d v=%b want 3/0/1", y, y_select, y_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_w [4];
        exp_w[0] = 4'hA; exp_w[1] = 4'hB; exp_w[2] = 4'hC; exp_w[3] = 4'hD;
        in0 = 4'hA; in1 = 4'hB; in2 = 4'hC; in3 = 4'hD;
        valid = 4'b1111; y_ready = 1; enable = 1;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (ready !== 4'(1 << (i % 4))) begin
                fails++;
                $display("FAIL rr_ready i=%0d: ready=%b want %b", i, ready, 4'(1 << (i % 4)));
            end
            tick();
            tests++;
            if (y !== exp_w[i % 4] || y_select !== 2'(i % 4) || y_valid !== 1'b1) begin
                fails++;
                $display("FAIL rr_word i=%0d: y=%h sel=%0d v=%b want %h/%0d/1", i, y, y_select, y_valid, exp_w[i % 4], i % 4);
            end
        end
    endtask

    task automatic test_skip_wrap();
        logic [3:0] exp_r [2];
        exp_r[0] = 4'b0001; exp_r[1] = 4'b0010;
        in0 = 4'h1; in1 = 4'h2; in2 = 4'hE; in3 = 4'hF;
        y_ready = 1; enable = 1;
        pulse_reset();
        valid = 4'b0010; #1;
        tick();                                   // lane 1 granted, ptr -> 2
        valid = 4'b0011; in1 = 4'h7; #1;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (ready !== exp_r[i] || ready !== model_ready()) begin
                fails++;
                $display("FAIL skip_wrap i=%0d: ready=%b want %b", i, ready, exp_r[i]);
            end
            tick();
            tests++;
            if (y_select !== 2'(i) || y !== ((i == 0) ? 4'h1 : 4'h7)) begin
                fails++;
                $display("FAIL skip_wrap_word i=%0d: y=%h sel=%0d", i, y, y_select);
            end
        end
    endtask

    task automatic test_backpressure();
        in0 = 4'h5; in2 = 4'h7; y_ready = 1; enable = 1;
        pulse_reset();
        valid = 4'b0001; #1;
        tick();                                   // y=5, ptr=1
        valid = 4'b0100; y_ready = 0; #1;
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (ready !== 4'b0000 || y !== 4'h5 || y_valid !== 1'b1 || y_select !== 2'd0) begin
                fails++;
                $display("FAIL bp_stall c=%0d: ready=%b y=%h v=%b want 0000/5/1", c, ready, y, y_valid);
            end
            tick();
        end
        y_ready = 1; #1;
        tests++;
        if (ready !== 4'b0100) begin
            fails++;
            $display("FAIL bp_release: ready=%b want 0100", ready);
        end
        tick();
        tests++;
        if (y !== 4'h7 || y_select !== 2'd2 || y_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_word: y=%h sel=%0d v=%b want 7/2/1", y, y_select, y_valid);
        end
    endtask

    task automatic test_enable();
        // Follows backpressure: y=7 held, ptr=3.
        in3 = 4'hC; valid = 4'b1111; enable = 0; y_ready = 1; #1;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (ready !== 4'b0000) begin
                fails++;
                $display("FAIL en_gate c=%0d: ready=%b want 0000", c, ready);
            end
            tick();
            tests++;
            if (y_valid !== 1'b0 || y !== 4'h7) begin
                fails++;
                $display("FAIL en_drain c=%0d: y_valid=%b y=%h want 0/7", c, y_valid, y);
            end
        end
        enable = 1; #1;
        tests++;
        if (ready !== 4'b1000) begin
            fails++;
            $display("FAIL en_resume: ready=%b want 1000", ready);
        end
        tick();
        tests++;
        if (y !== 4'hC || y_select !== 2'd3) begin
            fails++;
            $display("FAIL en_resume_word: y=%h sel=%0d want c/3", y, y_select);
        end
    endtask

    task automatic test_reset_mid_stall();
        in1 = 4'h9; y_ready = 1; enable = 1;
        pulse_reset();
        valid = 4'b0010; #1;
        tick();
        valid = 4'b0000; y_ready = 0; #1;
        tick();
        tests++;
        if (y !== 4'h9 || y_valid !== 1'b1 || y_select !== 2'd1) begin
            fails++;
            $display("FAIL mid_stall_hold: y=%h v=%b want 9/1", y, y_valid);
        end
        valid = 4'b1111; #2;
        assert_reset();                           // asynchronous, between edges
        tests++;
        if (y !== 4'h0 || y_valid !== 1'b0 || y_select !== 2'd0 || ready !== 4'b0000) begin
            fails++;
            $display("FAIL mid_stall_reset: y=%h v=%b sel=%0d ready=%b want 0/0/0/0000", y, y_valid, y_select, ready);
        end
        tick();
        rst_n = 1'b1; y_ready = 1; #1;
        tests++;
        if (ready !== 4'b0001) begin
            fails++;
            $display("FAIL mid_stall_restart: ready=%b want 0001", ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] held [4];
        logic [3:0] g;
        pulse_reset();
        valid = 4'b0000;
        for (int i = 0; i < 4; i++) held[i] = N'($urandom);
        for (int c = 0; c < 400; c++) begin
            // sources raise valid at will, then hold word until accepted
            for (int i = 0; i < 4; i++) begin
                if (!valid[i] && ($urandom_range(0, 2) != 0)) begin
                    valid[i] = 1'b1;
                    held[i]  = N'($urandom);
                end
            end
            in0 = held[0]; in1 = held[1]; in2 = held[2]; in3 = held[3];
            y_ready = ($urandom_range(0, 3) != 0);
            enable  = ($urandom_range(0, 7) != 0);
            #1;
            g = model_ready();
            tests++;
            if (ready !== g) begin
                fails++;
                $display("FAIL rand_ready c=%0d: ready=%b want %b", c, ready, g);
            end
            tick();
            valid = valid & ~g;
            tests++;
            if (y_valid !== m_yv || (m_yv && (y !== m_y || y_select !== 2'(m_sel)))) begin
                fails++;
                $display("FAIL rand_out c=%0d: v=%b y=%h sel=%0d want %b/%h/%0d", c, y_valid, y, y_select, m_yv, m_y, m_sel);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; valid = '0; y_ready = 1'b0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        m_ptr = 0; m_yv = 0; m_y = '0; m_sel = 0;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_enable();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
